// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Brief    : Shared types and constants for the bus timing controller:
//             FSM state encoding, request record, default timeout read
//             value and the watchdog counter width helper.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package bus_pkg;

    // Controller states; encoding is fixed so it can be observed in debug.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } bus_state_t;

    // Widths of the reference (default 32-bit) configuration.
    localparam int unsigned C_BUS_ADDR_W = 32;
    localparam int unsigned C_BUS_DATA_W = 32;
    localparam int unsigned C_BUS_BE_W   = C_BUS_DATA_W / 8;

    // Request record of the default configuration; the top declares the
    // same field layout sized by its own parameters.
    typedef struct packed {
        logic                    rw;
        logic [C_BUS_ADDR_W-1:0] address;
        logic [C_BUS_DATA_W-1:0] wdata;
        logic [C_BUS_BE_W-1:0]   byte_en;
    } bus_req_t;

    // Value returned on a read that was aborted by the watchdog.
    localparam logic [31:0] C_ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // Watchdog counter width: enough to hold TIMEOUT, never below one bit.
    function automatic int unsigned wd_cnt_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : bus_watchdog
//  Brief    : Wait-state counter. Cleared by i_clear, counts every cycle that
//             i_enable is high, and flags o_expired on the TIMEOUT-th enabled
//             cycle. TIMEOUT = 0 disables expiry entirely.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_watchdog
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned      CNT_W  = wd_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] C_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_match;

    // The counter holds once it reaches the last value so o_expired stays
    // stable if the owner lingers in the counting window.
    assign w_match   = (TIMEOUT != 0) && (r_count == C_LAST);
    assign o_expired = i_enable && w_match;

    // Wait-cycle counter: clear has priority over counting.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_match) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule : bus_watchdog
`default_nettype wire

// File: rtl/bus_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bus_timing_ctrl
//  Brief    : Request/ready sequencer between the CPU memory port and the
//             system bus. Registers the bus-side request, runs the
//             IDLE/SETUP/WAIT/DONE handshake and aborts hung transfers via a
//             watchdog, returning ERR_RDATA with o_cpu_error set.
//             Optional macro BUS_TIMING_CTRL_STATS_EN adds completion and
//             timeout counters (o_stat_txn, o_stat_timeout).
//  Revision : 1.0 - parametrised successor of the fixed 32-bit sequencer
// ============================================================================
module bus_timing_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        TIMEOUT   = 256,
    parameter logic [DATA_W-1:0]  ERR_RDATA = DATA_W'(C_ERR_RDATA_DEFAULT)
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_cpu_rw,
    input  logic                  i_cpu_request,
    output logic                  o_cpu_ready,
    output logic                  o_cpu_error,
    input  logic [ADDR_W-1:0]     i_cpu_address,
    input  logic [DATA_W-1:0]     i_cpu_wdata,
    input  logic [DATA_W/8-1:0]   i_cpu_byte_en,
    output logic [DATA_W-1:0]     o_cpu_rdata,
    output logic                  o_bus_rw,
    output logic                  o_bus_request,
    input  logic                  i_bus_ready,
    output logic [ADDR_W-1:0]     o_bus_address,
    output logic [DATA_W-1:0]     o_bus_wdata,
    output logic [DATA_W/8-1:0]   o_bus_byte_en,
    input  logic [DATA_W-1:0]     i_bus_rdata
`ifdef BUS_TIMING_CTRL_STATS_EN
    ,
    output logic [31:0]           o_stat_txn,
    output logic [31:0]           o_stat_timeout
`endif
);

    localparam int unsigned BE_W = DATA_W / 8;

    // Same layout as bus_pkg::bus_req_t, sized by this instance.
    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   byte_en;
    } req_t;

    bus_state_t        r_state;
    bus_state_t        w_state_nxt;
    req_t              r_req;
    req_t              w_req_nxt;
    logic              r_bus_request;
    logic              w_bus_request_nxt;
    logic              r_cpu_ready;
    logic              w_cpu_ready_nxt;
    logic              r_cpu_error;
    logic              w_cpu_error_nxt;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] w_cpu_rdata_nxt;

    logic              w_in_wait;
    logic              w_wd_clear;
    logic              w_wd_expired;

    assign w_in_wait = (r_state == ST_WAIT);

    bus_watchdog #(
        .TIMEOUT   (TIMEOUT)
    ) u_watchdog (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_wd_clear),
        .i_enable  (w_in_wait),
        .o_expired (w_wd_expired)
    );

    // Next-state and next-register logic; everything holds unless a state acts.
    always_comb begin
        w_state_nxt       = r_state;
        w_req_nxt         = r_req;
        w_bus_request_nxt = r_bus_request;
        w_cpu_ready_nxt   = r_cpu_ready;
        w_cpu_error_nxt   = r_cpu_error;
        w_cpu_rdata_nxt   = r_cpu_rdata;
        w_wd_clear        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cpu_ready_nxt = 1'b0;
                if (i_cpu_request) begin
                    w_req_nxt.rw      = i_cpu_rw;
                    w_req_nxt.address = i_cpu_address;
                    w_req_nxt.wdata   = i_cpu_wdata;
                    w_req_nxt.byte_en = i_cpu_byte_en;
                    w_state_nxt       = ST_SETUP;
                end
            end

            ST_SETUP: begin
                w_bus_request_nxt = 1'b1;
                w_wd_clear        = 1'b1;
                w_state_nxt       = ST_WAIT;
            end

            ST_WAIT: begin
                // A ready in the expiry cycle still counts as a good transfer.
                if (i_bus_ready) begin
                    if (!r_req.rw) begin
                        w_cpu_rdata_nxt = i_bus_rdata;
                    end
                    w_bus_request_nxt = 1'b0;
                    w_cpu_ready_nxt   = 1'b1;
                    w_cpu_error_nxt   = 1'b0;
                    w_state_nxt       = ST_DONE;
                end else if (w_wd_expired) begin
                    if (!r_req.rw) begin
                        w_cpu_rdata_nxt = ERR_RDATA;
                    end
                    w_bus_request_nxt = 1'b0;
                    w_cpu_ready_nxt   = 1'b1;
                    w_cpu_error_nxt   = 1'b1;
                    w_state_nxt       = ST_DONE;
                end
            end

            ST_DONE: begin
                if (!i_cpu_request) begin
                    w_cpu_ready_nxt = 1'b0;
                    w_cpu_error_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_req         <= '0;
            r_bus_request <= 1'b0;
            r_cpu_ready   <= 1'b0;
            r_cpu_error   <= 1'b0;
            r_cpu_rdata   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_req         <= w_req_nxt;
            r_bus_request <= w_bus_request_nxt;
            r_cpu_ready   <= w_cpu_ready_nxt;
            r_cpu_error   <= w_cpu_error_nxt;
            r_cpu_rdata   <= w_cpu_rdata_nxt;
        end
    end

    assign o_cpu_ready   = r_cpu_ready;
    assign o_cpu_error   = r_cpu_error;
    assign o_cpu_rdata   = r_cpu_rdata;
    assign o_bus_rw      = r_req.rw;
    assign o_bus_request = r_bus_request;
    assign o_bus_address = r_req.address;
    assign o_bus_wdata   = r_req.wdata;
    assign o_bus_byte_en = r_req.byte_en;

`ifdef BUS_TIMING_CTRL_STATS_EN
    logic        w_stat_done;
    logic        w_stat_abort;
    logic [31:0] r_stat_txn;
    logic [31:0] r_stat_timeout;

    assign w_stat_done  = w_in_wait && (i_bus_ready || w_wd_expired);
    assign w_stat_abort = w_in_wait && !i_bus_ready && w_wd_expired;

    // Free-running statistics; both wrap naturally at 2^32.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_stat_txn     <= '0;
            r_stat_timeout <= '0;
        end else begin
            if (w_stat_done) begin
                r_stat_txn <= r_stat_txn + 32'd1;
            end
            if (w_stat_abort) begin
                r_stat_timeout <= r_stat_timeout + 32'd1;
            end
        end
    end

    assign o_stat_txn     = r_stat_txn;
    assign o_stat_timeout = r_stat_timeout;
`endif

endmodule : bus_timing_ctrl
`default_nettype wire

// File: tb/tb_bus_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_timing_ctrl
//  Brief    : Self-checking bench for bus_timing_ctrl (ADDR_W=24, DATA_W=64,
//             TIMEOUT=16). Table of transfers with expected results queued
//             at stimulus time and compared on completion, plus hand-written
//             reset-in-WAIT and ready-outside-WAIT sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_timing_ctrl;

    localparam int unsigned ADDR_W  = 24;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [DATA_W-1:0] C_ERR = 64'h0000_0000_DEAD_BEEF;

    logic              clk = 1'b0;
    logic              i_reset_n;
    logic              i_cpu_rw;
    logic              i_cpu_request;
    logic              o_cpu_ready;
    logic              o_cpu_error;
    logic [ADDR_W-1:0] i_cpu_address;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic [BE_W-1:0]   i_cpu_byte_en;
    logic [DATA_W-1:0] o_cpu_rdata;
    logic              o_bus_rw;
    logic              o_bus_request;
    logic              i_bus_ready;
    logic [ADDR_W-1:0] o_bus_address;
    logic [DATA_W-1:0] o_bus_wdata;
    logic [BE_W-1:0]   o_bus_byte_en;
    logic [DATA_W-1:0] i_bus_rdata;

    always #5 clk = ~clk;

    bus_timing_ctrl #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (i_reset_n),
        .i_cpu_rw      (i_cpu_rw),
        .i_cpu_request (i_cpu_request),
        .o_cpu_ready   (o_cpu_ready),
        .o_cpu_error   (o_cpu_error),
        .i_cpu_address (i_cpu_address),
        .i_cpu_wdata   (i_cpu_wdata),
        .i_cpu_byte_en (i_cpu_byte_en),
        .o_cpu_rdata   (o_cpu_rdata),
        .o_bus_rw      (o_bus_rw),
        .o_bus_request (o_bus_request),
        .i_bus_ready   (i_bus_ready),
        .o_bus_address (o_bus_address),
        .o_bus_wdata   (o_bus_wdata),
        .o_bus_byte_en (o_bus_byte_en),
        .i_bus_rdata   (i_bus_rdata)
    );

    // delay: bus ready raised d cycles after o_bus_request rises (0 = never)
    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] bus_rdata;
        int                delay;
        logic              scramble;
        logic              exp_err;
        int                exp_lat;
    } vec_t;

    typedef struct {
        logic              err;
        logic [DATA_W-1:0] rdata;
        int                lat;
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } exp_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];
    exp_t sb [$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [DATA_W-1:0] m_rdata;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        i_cpu_rw      = v.rw;
        i_cpu_address = v.addr;
        i_cpu_wdata   = v.wdata;
        i_cpu_byte_en = v.be;
        i_bus_rdata   = v.bus_rdata;
        i_bus_ready   = 1'b0;
        i_cpu_request = 1'b1;
        if (!v.rw) m_rdata = v.exp_err ? C_ERR : v.bus_rdata;
        e.err   = v.exp_err;
        e.rdata = m_rdata;
        e.lat   = v.exp_lat;
        e.rw    = v.rw;
        e.addr  = v.addr;
        e.wdata = v.wdata;
        e.be    = v.be;
        sb.push_back(e);
        n    = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (o_cpu_ready) begin
                seen = 1;
            end else begin
                if (n == 1 && v.scramble) begin
                    i_cpu_address = ~v.addr;
                    i_cpu_wdata   = ~v.wdata;
                    i_cpu_byte_en = ~v.be;
                end
                if (v.delay != 0 && n == v.delay + 1) i_bus_ready = 1'b1;
            end
        end
        i_bus_ready = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL v%0d_no_ready: got no o_cpu_ready in 100 cycles, expected one", idx);
        end else begin
            check($sformatf("v%0d_latency", idx), 64'(n), 64'(e.lat));
            check($sformatf("v%0d_error", idx), 64'(o_cpu_error), 64'(e.err));
            check($sformatf("v%0d_rdata", idx), o_cpu_rdata, e.rdata);
            check($sformatf("v%0d_bus_req_low", idx), 64'(o_bus_request), 64'd0);
            check($sformatf("v%0d_bus_addr", idx), 64'(o_bus_address), 64'(e.addr));
            check($sformatf("v%0d_bus_wdata", idx), o_bus_wdata, e.wdata);
            check($sformatf("v%0d_bus_be", idx), 64'(o_bus_byte_en), 64'(e.be));
            check($sformatf("v%0d_bus_rw", idx), 64'(o_bus_rw), 64'(e.rw));
            // Ready must hold while the CPU keeps requesting.
            @(posedge clk); #1;
            check($sformatf("v%0d_ready_held", idx), 64'(o_cpu_ready), 64'd1);
        end
        @(negedge clk);
        i_cpu_request = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d_ready_drop", idx), 64'(o_cpu_ready), 64'd0);
        check($sformatf("v%0d_error_drop", idx), 64'(o_cpu_error), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int rise;
        vecs[0] = '{1'b0, 24'h000010, 64'h0,                     8'hFF, 64'h0000_0000_1234_5678, 2,  1'b0, 1'b0, 4};
        vecs[1] = '{1'b1, 24'h001000, 64'h0000_0000_CAFE_F00D,   8'h03, 64'h0,                   1,  1'b1, 1'b0, 3};
        vecs[2] = '{1'b0, 24'h000020, 64'h0,                     8'hFF, 64'h0000_0000_0000_1111, 0,  1'b0, 1'b1, 18};
        vecs[3] = '{1'b0, 24'h000030, 64'h0,                     8'h0F, 64'h55AA_55AA_0F0F_F0F0, 16, 1'b0, 1'b0, 18};
        vecs[4] = '{1'b0, 24'h000040, 64'h0,                     8'hFF, 64'h0000_0000_0000_2222, 17, 1'b0, 1'b1, 18};
        vecs[5] = '{1'b1, 24'hFFFFFC, 64'hFFFF_0000_A5A5_5A5A,   8'hFF, 64'h0,                   15, 1'b0, 1'b0, 17};
        vecs[6] = '{1'b0, 24'hABCDEF, 64'h0,                     8'hFF, 64'h0123_4567_89AB_CDEF, 3,  1'b0, 1'b0, 5};
        vecs[7] = '{1'b1, 24'h000100, 64'h0000_0000_0000_0077,   8'h80, 64'h0,                   0,  1'b0, 1'b1, 18};
        vecs[8] = '{1'b0, 24'h000200, 64'h0,                     8'hFF, 64'hFEDC_BA98_7654_3210, 1,  1'b0, 1'b0, 3};

        i_reset_n     = 1'b0;
        i_cpu_rw      = 1'b0;
        i_cpu_request = 1'b0;
        i_cpu_address = '0;
        i_cpu_wdata   = '0;
        i_cpu_byte_en = '0;
        i_bus_ready   = 1'b0;
        i_bus_rdata   = '0;
        m_rdata       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", 64'(o_cpu_ready), 64'd0);
        check("rst_cpu_error", 64'(o_cpu_error), 64'd0);
        check("rst_bus_request", 64'(o_bus_request), 64'd0);
        check("rst_bus_rw", 64'(o_bus_rw), 64'd0);
        check("rst_cpu_rdata", o_cpu_rdata, 64'd0);
        check("rst_bus_addr", 64'(o_bus_address), 64'd0);
        check("rst_bus_wdata", o_bus_wdata, 64'd0);
        check("rst_bus_be", 64'(o_bus_byte_en), 64'd0);
        @(negedge clk);
        i_reset_n = 1'b1;

        // Bus ready while idle must not produce a completion or a request.
        @(negedge clk);
        i_bus_ready = 1'b1;
        rise = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (o_cpu_ready || o_bus_request) rise++;
        end
        i_bus_ready = 1'b0;
        check("idle_ready_ignored", 64'(rise), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset in the middle of WAIT: request drops, no completion.
        @(negedge clk);
        i_cpu_rw      = 1'b0;
        i_cpu_address = 24'h000300;
        i_cpu_request = 1'b1;
        i_bus_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstwait_bus_req_high", 64'(o_bus_request), 64'd1);
        @(negedge clk);
        i_reset_n = 1'b0;
        @(posedge clk); #1;
        m_rdata = '0;
        check("rstwait_bus_req", 64'(o_bus_request), 64'd0);
        check("rstwait_cpu_ready", 64'(o_cpu_ready), 64'd0);
        check("rstwait_cpu_rdata", o_cpu_rdata, 64'd0);
        check("rstwait_bus_addr", 64'(o_bus_address), 64'd0);
        @(negedge clk);
        i_reset_n     = 1'b1;
        i_cpu_request = 1'b0;
        rise = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o_cpu_ready || o_bus_request) rise++;
        end
        check("rstwait_no_completion", 64'(rise), 64'd0);

        for (int i = 7; i < NVEC; i++) run_vec(vecs[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_bus_timing_ctrl
`default_nettype wire

// File: doc/bus_timing_ctrl.md
Name: bus_timing_ctrl

Overview:
Parametrised bus timing controller between the CPU memory port and the system bus. It is the successor of the fixed 32-bit request/ready sequencer, with these additions:
- generic address and data widths;
- byte enables;
- registered bus-side address, data and control;
- a bus-timeout watchdog that completes a hung transfer with an error flag and a defined read value.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; multiple of 8
TIMEOUT, 256, WAIT-state cycles before abort; 0 disables the watchdog
ERR_RDATA, 32'hDEAD_BEEF, read data on timeout (truncated/zero-extended to DATA_W)

Ports:
i_clock  in  1  clock; all logic on rising edge
i_reset_n  in  1  synchronous active-low reset
i_cpu_rw  in  1  1 = write, 0 = read
i_cpu_request  in  1  CPU transfer request; level, held until o_cpu_ready
o_cpu_ready  out  1  transfer complete; held until request drops
o_cpu_error  out  1  valid with o_cpu_ready; 1 = timed out
i_cpu_address  in  ADDR_W  CPU address
i_cpu_wdata  in  DATA_W  CPU write data
i_cpu_byte_en  in  DATA_W/8  CPU byte lane enables
o_cpu_rdata  out  DATA_W  registered read data
o_bus_rw  out  1  registered copy of rw
o_bus_request  out  1  bus request
i_bus_ready  in  1  bus completion strobe/level
o_bus_address  out  ADDR_W  registered address
o_bus_wdata  out  DATA_W  registered write data
o_bus_byte_en  out  DATA_W/8  registered byte enables
i_bus_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - state = IDLE; o_cpu_ready, o_cpu_error, o_bus_request, o_bus_rw = 0.
  - o_cpu_rdata, o_bus_address, o_bus_wdata, o_bus_byte_en = 0; watchdog counter = 0.
  - Reset mid-transfer drops o_bus_request on that edge; no completion is reported.
- States IDLE, SETUP, WAIT, DONE:
  - IDLE: o_cpu_ready <= 0. If i_cpu_request: latch address, wdata, byte_en and rw into the o_bus_* registers; -> SETUP.
  - SETUP: o_bus_request <= 1; counter <= 0; -> WAIT.
  - WAIT, i_bus_ready = 1:
    - if read, o_cpu_rdata <= i_bus_rdata; writes leave o_cpu_rdata unchanged;
    - o_bus_request <= 0; o_cpu_ready <= 1; o_cpu_error <= 0; -> DONE.
  - WAIT, timeout: taken when TIMEOUT != 0, i_bus_ready = 0 and counter == TIMEOUT-1.
    - o_bus_request <= 0; o_cpu_ready <= 1; o_cpu_error <= 1;
    - o_cpu_rdata <= ERR_RDATA for reads;
    - -> DONE.
  - WAIT, otherwise: counter <= counter+1.
  - DONE: if !i_cpu_request: o_cpu_ready <= 0, o_cpu_error <= 0; -> IDLE. Otherwise hold.
- Latency:
  - Request sampled at edge k; o_bus_request high after edge k+1; ready sampled at edge k+2 at the earliest; o_cpu_ready high after edge k+2.
  - Minimum 3 cycles request-to-ready.
  - A timeout asserts o_cpu_ready TIMEOUT+2 cycles after the request is sampled.
- i_bus_ready coinciding with the timeout cycle: ready wins, no error.
- i_bus_ready outside WAIT is ignored.
- CPU inputs are sampled only in IDLE; later changes do not affect the bus outputs.
- Back-to-back: a new request needs one IDLE cycle after the previous request drops.
- Counter width is $clog2(TIMEOUT+1), minimum 1. With TIMEOUT = 0, WAIT never aborts.

Optional Feature:
BUS_TIMING_CTRL_STATS_EN:
- Defined: adds outputs o_stat_txn (32-bit, +1 on every completion, ok or error) and o_stat_timeout (32-bit, +1 per timeout).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package bus_pkg holds:
  - state enum (IDLE=0, SETUP=1, WAIT=2, DONE=3);
  - a bus_req_t struct (rw, address, wdata, byte_en), parametrised via localparams;
  - the default ERR_RDATA constant.
- One natural sub-module: bus_watchdog (clear, enable, TIMEOUT param -> expired pulse).

Test Plan:
- Read, bus ready 2 cycles after o_bus_request, rdata 32'h1234_5678 -> o_cpu_ready at request+4 cycles, o_cpu_rdata = 32'h1234_5678, o_cpu_error = 0.
- Write addr 32'h0000_1000, wdata 32'hCAFE_F00D, byte_en 4'b0011, CPU changes address during WAIT -> o_bus_address / o_bus_wdata / o_bus_byte_en hold the latched values; o_cpu_rdata unchanged.
- TIMEOUT=16, read, ready never asserted -> o_bus_request drops; o_cpu_ready high 18 cycles after request; o_cpu_error = 1; o_cpu_rdata = 32'hDEAD_BEEF.
- TIMEOUT=16, i_bus_ready on the 16th WAIT cycle -> normal completion, o_cpu_error = 0.
- i_reset_n low in WAIT -> next cycle o_bus_request = 0, o_cpu_ready = 0, state IDLE; next request completes normally.
- STATS_EN, 3 good reads + 1 timeout -> o_stat_txn = 4, o_stat_timeout = 1; DATA_W=64, ADDR_W=24 read returns 64'h0123_4567_89AB_CDEF intact.
